// File: rtl/serial_transmitter.sv
// serial_transmitter
//   Transmit side of the serial link. Serializes bytes into framed bits:
//   start bit (0), DATA_WIDTH data bits LSB-first, optional odd parity bit,
//   STOP_BITS stop bits (1). The line idles high. A one-entry holding buffer
//   lets a second byte queue up during a frame so frames run back-to-back.
//
//   Build option: define TX_PARITY_EN to include the odd parity bit after the
//   data bits. Without it the frame goes straight from data to stop bits.
//
// Parameters
//   DATA_WIDTH   payload bits per frame
//   CLKS_PER_BIT clk cycles per serial bit period (>= 1)
//   STOP_BITS    stop bits per frame (1 or 2)
//
// Ports
//   clk       in   clock, all logic on rising edge
//   arst      in   synchronous active-high reset
//   in_valid  in   in_byte valid
//   in_ready  out  holding buffer empty, byte can be accepted
//   in_byte   in   byte to send
//   out       out  registered serial line
//   busy      out  frame in progress
//   done      out  one-cycle pulse in the last clk of the last stop bit
module serial_transmitter #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 1,
  parameter int STOP_BITS    = 1
) (
  input  logic                  clk,
  input  logic                  arst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_byte,
  output logic                  out,
  output logic                  busy,
  output logic                  done
);

  localparam int BAUD_W  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int CNT_MAX = (DATA_WIDTH > STOP_BITS) ? DATA_WIDTH : STOP_BITS;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] BAUD_PRE  = BAUD_W'((CLKS_PER_BIT > 1) ? CLKS_PER_BIT - 2 : 0);
  localparam logic [CNT_W-1:0]  DATA_LAST = CNT_W'(DATA_WIDTH - 1);
  localparam logic [CNT_W-1:0]  STOP_LAST = CNT_W'(STOP_BITS - 1);

  // With one clk per bit and a single stop bit, the whole stop bit is its own
  // last clk, so done must be raised on the edge that enters STOP.
  localparam logic ENTER_STOP_DONE = (CLKS_PER_BIT == 1) && (STOP_BITS == 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t                  state;
  logic [BAUD_W-1:0]       baud;
  logic [CNT_W-1:0]        bitcnt;
  logic                    hold_full;
  logic [DATA_WIDTH-1:0]   hold;
  logic [DATA_WIDTH-1:0]   shifter;
`ifdef TX_PARITY_EN
  logic                    par;
`endif

  logic bit_end;
  logic frame_end;
  logic load;
  logic accept;

  assign bit_end   = (baud == BAUD_LAST);
  assign frame_end = (state == STOP) && bit_end && (bitcnt == STOP_LAST);
  // Hold drains into the shifter either from idle or straight at the end of
  // the previous frame, which is what removes the idle gap between frames.
  assign load      = hold_full && ((state == IDLE) || frame_end);
  assign accept    = in_valid && !hold_full;
  assign in_ready  = !hold_full;
  assign busy      = (state != IDLE);

  // Payload registers: no reset needed, their contents only matter once the
  // control path marks them valid.
  always_ff @(posedge clk) begin
    if (accept) begin
      hold <= in_byte;
    end
    if (load) begin
      shifter <= hold;
`ifdef TX_PARITY_EN
      // Parity comes from the loaded byte, the shifter is consumed as it goes.
      par     <= ~^hold;
`endif
    end else if (state == DATA && bit_end) begin
      shifter <= shifter >> 1;
    end
  end

  always_ff @(posedge clk) begin
    if (arst) begin
      state     <= IDLE;
      out       <= 1'b1;
      done      <= 1'b0;
      baud      <= '0;
      bitcnt    <= '0;
      hold_full <= 1'b0;
    end else begin
      done <= 1'b0;

      // load and accept are mutually exclusive: accept needs hold empty.
      if (load) begin
        hold_full <= 1'b0;
      end else if (accept) begin
        hold_full <= 1'b1;
      end

      if (load) begin
        state  <= START;
        out    <= 1'b0;
        baud   <= '0;
        bitcnt <= '0;
      end else if (state == IDLE) begin
        out    <= 1'b1;
        baud   <= '0;
        bitcnt <= '0;
      end else if (!bit_end) begin
        baud <= baud + 1'b1;
        // Next clk is the final clk of the final stop bit.
        if ((CLKS_PER_BIT > 1) && (state == STOP) && (bitcnt == STOP_LAST) &&
            (baud == BAUD_PRE)) begin
          done <= 1'b1;
        end
      end else begin
        baud <= '0;
        case (state)
          START: begin
            state  <= DATA;
            bitcnt <= '0;
            out    <= shifter[0];
          end
          DATA: begin
            if (bitcnt == DATA_LAST) begin
`ifdef TX_PARITY_EN
              state  <= PARITY;
              out    <= par;
`else
              state  <= STOP;
              out    <= 1'b1;
              done   <= ENTER_STOP_DONE;
`endif
              bitcnt <= '0;
            end else begin
              bitcnt <= bitcnt + 1'b1;
              // shifter[1] becomes shifter[0] on this same edge.
              out    <= shifter[1];
            end
          end
`ifdef TX_PARITY_EN
          PARITY: begin
            state  <= STOP;
            out    <= 1'b1;
            bitcnt <= '0;
            done   <= ENTER_STOP_DONE;
          end
`endif
          STOP: begin
            out <= 1'b1;
            if (bitcnt == STOP_LAST) begin
              // Hold empty here, otherwise the load branch would have fired.
              state  <= IDLE;
              bitcnt <= '0;
            end else begin
              bitcnt <= bitcnt + 1'b1;
              done   <= (CLKS_PER_BIT == 1) && (CNT_W'(bitcnt + 1'b1) == STOP_LAST);
            end
          end
          default: begin
            state <= IDLE;
            out   <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule
